// File: rtl/seg7_frame_capture.sv
// Recovers hex digits and DP from a multiplexed active-low 7-segment bus; optional blank decode via SEG7_CAP_BLANK_EN.
// Latency: a digit commits on the STABLE_CYCLES-th edge that registers an unchanged legal sample.
// Backpressure: none; observe-only monitor, en=0 freezes outputs and suppresses commits.
module seg7_frame_capture #(
   parameter int NUM_DIGITS    = 8,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic [NUM_DIGITS-1:0]   an_n,
   input  logic [7:0]              seg_n,
   output logic [4*NUM_DIGITS-1:0] digits_out,
   output logic [NUM_DIGITS-1:0]   dp_out,
   output logic [NUM_DIGITS-1:0]   digit_err,
   output logic [NUM_DIGITS-1:0]   blank_out,
   output logic                    frame_valid,
   output logic                    frame_err
);

   typedef struct packed {
      logic [NUM_DIGITS-1:0] an;
      logic [7:0]            seg;
   } sample_t;

   localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);

   sample_t                         bus_dat;
   sample_t                         s_dat;
   logic    [7:0]                   cnt;
   logic    [7:0]                   cnt_nxt;
   logic                            bus_legal;
   logic                            commit_vld;
   logic                            blank_pat;
   logic    [4:0]                   dec_dat;
   logic    [NUM_DIGITS-1:0]        sel;
   logic    [NUM_DIGITS-1:0]        seen_q;
   logic    [NUM_DIGITS-1:0]        seen_nxt;
   logic                            frame_done;
   logic    [NUM_DIGITS-1:0][3:0]   dig_q;
   logic    [NUM_DIGITS-1:0][3:0]   dig_nxt;
   logic    [NUM_DIGITS-1:0]        dp_q;
   logic    [NUM_DIGITS-1:0]        dp_nxt;
   logic    [NUM_DIGITS-1:0]        err_q;
   logic    [NUM_DIGITS-1:0]        err_nxt;
   logic    [NUM_DIGITS-1:0]        blank_q;
   logic    [NUM_DIGITS-1:0]        blank_nxt;

   function automatic logic one_low(input logic [NUM_DIGITS-1:0] an);
      int zeros;
      zeros = 0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (!an[i]) zeros++;
      end
      return (zeros == 1);
   endfunction

   // {valid, nibble} for active-low A..G
   function automatic logic [4:0] decode(input logic [6:0] p);
      logic [4:0] r;
      case (p)
         7'b0000001: r = {1'b1, 4'h0};
         7'b1001111: r = {1'b1, 4'h1};
         7'b0010010: r = {1'b1, 4'h2};
         7'b0000110: r = {1'b1, 4'h3};
         7'b1001100: r = {1'b1, 4'h4};
         7'b0100100: r = {1'b1, 4'h5};
         7'b0100000: r = {1'b1, 4'h6};
         7'b0001111: r = {1'b1, 4'h7};
         7'b0000000: r = {1'b1, 4'h8};
         7'b0000100: r = {1'b1, 4'h9};
         7'b0001000: r = {1'b1, 4'hA};
         7'b1100000: r = {1'b1, 4'hB};
         7'b0110001: r = {1'b1, 4'hC};
         7'b1000010: r = {1'b1, 4'hD};
         7'b0110000: r = {1'b1, 4'hE};
         7'b0111000: r = {1'b1, 4'hF};
         default:    r = 5'b0;
      endcase
      return r;
   endfunction

   assign bus_dat = '{an: an_n, seg: seg_n};

`ifdef SEG7_CAP_BLANK_EN
   assign blank_pat = (s_dat.seg[7:1] == 7'b1111111);
`else
   assign blank_pat = 1'b0;
`endif

   // The incoming sample is compared against the registered one so that cnt
   // already counts the sample being captured on this edge; once cnt reaches
   // 2 the registered copy equals the bus, so commit data comes from s_dat.
   always_comb begin
      bus_legal = one_low(bus_dat.an);
      if (!en || !bus_legal)      cnt_nxt = 8'd0;
      else if (bus_dat != s_dat)  cnt_nxt = 8'd1;
      else if (cnt == CNT_MAX)    cnt_nxt = cnt;
      else                        cnt_nxt = cnt + 8'd1;
      commit_vld = (cnt_nxt == CNT_MAX) && (cnt != CNT_MAX);
   end

   always_comb begin
      sel       = ~s_dat.an & {NUM_DIGITS{commit_vld}};
      dec_dat   = decode(s_dat.seg[7:1]);
      dig_nxt   = dig_q;
      dp_nxt    = dp_q;
      err_nxt   = err_q;
      blank_nxt = blank_q;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (sel[i]) begin
            dp_nxt[i] = ~s_dat.seg[0];
            if (dec_dat[4]) begin
               dig_nxt[i]   = dec_dat[3:0];
               err_nxt[i]   = 1'b0;
               blank_nxt[i] = 1'b0;
            end else if (blank_pat) begin
               err_nxt[i]   = 1'b0;
               blank_nxt[i] = 1'b1;
            end else begin
               err_nxt[i]   = 1'b1;
            end
         end
      end
      seen_nxt   = seen_q | sel;
      frame_done = commit_vld && (&seen_nxt);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_dat       <= '0;
         cnt         <= '0;
         seen_q      <= '0;
         dig_q       <= '0;
         dp_q        <= '0;
         err_q       <= '0;
         blank_q     <= '0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         s_dat       <= bus_dat;
         cnt         <= cnt_nxt;
         seen_q      <= frame_done ? '0 : seen_nxt;
         dig_q       <= dig_nxt;
         dp_q        <= dp_nxt;
         err_q       <= err_nxt;
         blank_q     <= blank_nxt;
         frame_valid <= frame_done;
         if (frame_done) frame_err <= |err_nxt;
      end
   end

   assign digits_out = dig_q;
   assign dp_out     = dp_q;
   assign digit_err  = err_q;
   assign blank_out  = blank_q;

endmodule
